// File: rtl/led_frame_sequencer.sv
// Feeds one frame of WS2812 GRB pixels, MSB first, to the bit transmitter with one pixel prefetched.
// Optional build macro BRIGHTNESS_SCALE_EN scales each channel by (brightness+1)/256 on load.
module led_frame_sequencer #(
    parameter int NUM_LEDS = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              new_frame_rqst,
    input  logic              new_bit_rqst,
    output logic              bit_to_transmit,
    output logic              bit_valid,
    output logic              all_bits_shifted,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [23:0]       fb_rd_data,
    output logic              busy,
    output logic              frame_done,
    input  logic [7:0]        brightness
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] led_idx;
    logic [ADDR_W-1:0] idx_inc;
    logic [4:0]        bit_cnt;
    logic [23:0]       shreg;
    logic [23:0]       nxt_pix;
    logic              nxt_valid;
    logic              pending;
    logic              pf_land;
    logic              start_req;
    logic [23:0]       pix_in;

`ifdef BRIGHTNESS_SCALE_EN
    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, ch} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    assign pix_in = {scale_ch(fb_rd_data[23:16], brightness),
                     scale_ch(fb_rd_data[15:8],  brightness),
                     scale_ch(fb_rd_data[7:0],   brightness)};
`else
    logic unused_brightness;

    assign pix_in            = fb_rd_data;
    assign unused_brightness = &{1'b0, brightness};
`endif

    assign idx_inc          = led_idx + ADDR_W'(1);
    assign start_req        = frame_start || pending;
    assign bit_to_transmit  = shreg[23];
    assign all_bits_shifted = bit_valid && (led_idx == LAST_IDX) && (bit_cnt == 5'd23);

    // NOTE: the shift and prefetch registers carry an async reset too, so every output is a
    // known 0 straight out of reset, including bit_to_transmit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            led_idx    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            nxt_pix    <= '0;
            nxt_valid  <= 1'b0;
            pending    <= 1'b0;
            pf_land    <= 1'b0;
            bit_valid  <= 1'b0;
            fb_rd_en   <= 1'b0;
            fb_addr    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are raised below; non-blocking
            // assignment lets the later case arms override these defaults cleanly.
            fb_rd_en   <= 1'b0;
            frame_done <= 1'b0;

            // A prefetch read issued during SHIFT returns data one cycle after fb_rd_en.
            pf_land <= fb_rd_en && (state == SHIFT);
            if (pf_land) begin
                nxt_pix   <= pix_in;
                nxt_valid <= 1'b1;
            end

            if (frame_start && state != IDLE) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_req && new_frame_rqst) begin
                        pending  <= 1'b0;
                        busy     <= 1'b1;
                        led_idx  <= '0;
                        fb_addr  <= '0;
                        fb_rd_en <= 1'b1;
                        state    <= FETCH;
                    end else if (frame_start) begin
                        pending <= 1'b1;
                    end
                end

                FETCH: state <= LOAD;

                LOAD: begin
                    shreg     <= pix_in;
                    bit_cnt   <= '0;
                    bit_valid <= 1'b1;
                    nxt_valid <= 1'b0;
                    state     <= SHIFT;
                    if (led_idx != LAST_IDX) begin
                        fb_rd_en <= 1'b1;
                        fb_addr  <= idx_inc;
                    end
                end

                SHIFT: begin
                    if (!bit_valid) begin
                        // Stalled at a pixel boundary until the prefetch lands.
                        if (nxt_valid) begin
                            shreg     <= nxt_pix;
                            nxt_valid <= 1'b0;
                            bit_valid <= 1'b1;
                            if (led_idx != LAST_IDX) begin
                                fb_rd_en <= 1'b1;
                                fb_addr  <= idx_inc;
                            end
                        end
                    end else if (new_bit_rqst) begin
                        if (bit_cnt != 5'd23) begin
                            shreg   <= {shreg[22:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end else if (led_idx == LAST_IDX) begin
                            bit_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            led_idx <= idx_inc;
                            bit_cnt <= '0;
                            if (nxt_valid) begin
                                shreg     <= nxt_pix;
                                nxt_valid <= 1'b0;
                                if (idx_inc != LAST_IDX) begin
                                    fb_rd_en <= 1'b1;
                                    fb_addr  <= idx_inc + ADDR_W'(1);
                                end
                            end else begin
                                bit_valid <= 1'b0;
                            end
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench: a two-LED instance for frame content and corner cases, a 64-LED
// instance for a back-to-back bit-request frame.
module tb_led_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Two-LED instance
    logic        frame_start, new_frame_rqst, new_bit_rqst;
    logic [7:0]  brightness;
    logic        bit_to_transmit, bit_valid, all_bits_shifted, fb_rd_en, busy, frame_done;
    logic [5:0]  fb_addr;
    logic [23:0] fb_rd_data;
    logic [23:0] mem2 [64];
    logic [5:0]  addr_log [$];
    int          done_cnt = 0;

    led_frame_sequencer #(.NUM_LEDS(2), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .new_frame_rqst(new_frame_rqst),
        .new_bit_rqst(new_bit_rqst), .bit_to_transmit(bit_to_transmit), .bit_valid(bit_valid),
        .all_bits_shifted(all_bits_shifted), .fb_rd_en(fb_rd_en), .fb_addr(fb_addr),
        .fb_rd_data(fb_rd_data), .busy(busy), .frame_done(frame_done), .brightness(brightness)
    );

    always @(posedge clk) begin
        if (fb_rd_en) begin
            fb_rd_data <= mem2[fb_addr];
            addr_log.push_back(fb_addr);
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    // 64-LED instance
    logic        b_frame_start, b_new_frame_rqst, b_new_bit_rqst;
    logic [7:0]  b_brightness;
    logic        b_bit_to_transmit, b_bit_valid, b_all_bits_shifted, b_fb_rd_en, b_busy, b_frame_done;
    logic [5:0]  b_fb_addr;
    logic [23:0] b_fb_rd_data;
    logic [23:0] mem64 [64];
    logic [5:0]  b_addr_log [$];
    int          b_done_cnt = 0;

    led_frame_sequencer #(.NUM_LEDS(64), .ADDR_W(6)) dut64 (
        .clk(clk), .rst(rst), .frame_start(b_frame_start), .new_frame_rqst(b_new_frame_rqst),
        .new_bit_rqst(b_new_bit_rqst), .bit_to_transmit(b_bit_to_transmit), .bit_valid(b_bit_valid),
        .all_bits_shifted(b_all_bits_shifted), .fb_rd_en(b_fb_rd_en), .fb_addr(b_fb_addr),
        .fb_rd_data(b_fb_rd_data), .busy(b_busy), .frame_done(b_frame_done), .brightness(b_brightness)
    );

    always @(posedge clk) begin
        if (b_fb_rd_en) begin
            b_fb_rd_data <= mem64[b_fb_addr];
            b_addr_log.push_back(b_fb_addr);
        end
        if (b_frame_done) b_done_cnt <= b_done_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0] pix0;
        logic [23:0] pix1;
        logic [7:0]  bright;
        logic [47:0] exp_bits;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic addr_seq_ok(input logic [5:0] q [$], input int n);
        if (q.size() != n) return 1'b0;
        for (int i = 0; i < n; i++) if (q[i] != 6'(i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Consumes n bits on the two-LED instance, one request every gap cycles; called at a negedge.
    task automatic run_frame(input int n, input int gap, output logic [47:0] stream,
                             output int hits, output int pos, output int drops);
        stream = '0;
        hits   = 0;
        pos    = -1;
        drops  = 0;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!bit_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (i > 0 && t > 0) drops++;
            if (!bit_valid) begin
                check("bit_valid_wait", bit_valid, 1);
                return;
            end
            stream = {stream[46:0], bit_to_transmit};
            if (all_bits_shifted) begin
                hits++;
                pos = i;
            end
            new_bit_rqst = 1'b1;
            @(negedge clk);
            new_bit_rqst = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    logic [47:0] got;
    int          hits, pos, drops, d0, seen;

    initial begin
        vecs[0] = '{24'hA50F3C, 24'h000001, 8'hFF, 48'hA50F3C_000001};
        vecs[1] = '{24'hFFFFFF, 24'h800000, 8'hFF, 48'hFFFFFF_800000};
        vecs[2] = '{24'hFF8002, 24'h123456, 8'hFF, 48'hFF8002_123456};
`ifdef BRIGHTNESS_SCALE_EN
        vecs[3] = '{24'hFF8002, 24'h0000FF, 8'h7F, 48'h7F4001_00007F};
`else
        vecs[3] = '{24'hFF8002, 24'h0000FF, 8'h7F, 48'hFF8002_0000FF};
`endif
        for (int i = 0; i < 64; i++) begin
            mem2[i]  = 24'hDEAD00 | 24'(i);
            mem64[i] = {8'(i), 8'h5A ^ 8'(i), 8'(i * 7)};
        end

        rst = 1'b0;
        frame_start = 1'b0; new_frame_rqst = 1'b1; new_bit_rqst = 1'b0; brightness = 8'hFF;
        b_frame_start = 1'b0; b_new_frame_rqst = 1'b1; b_new_bit_rqst = 1'b0; b_brightness = 8'hFF;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bit_to_transmit, bit_valid, all_bits_shifted, fb_rd_en, busy, frame_done}, 0);
        check("reset_fb_addr", fb_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame content, all_bits_shifted placement, completion, read order.
        for (int v = 0; v < 4; v++) begin
            mem2[0] = vecs[v].pix0;
            mem2[1] = vecs[v].pix1;
            brightness = vecs[v].bright;
            addr_log.delete();
            d0 = done_cnt;
            pulse_start();
            run_frame(48, 30, got, hits, pos, drops);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_bits", v), got, vecs[v].exp_bits);
            check($sformatf("v%0d_abs_hits", v), hits, 1);
            check($sformatf("v%0d_abs_pos", v), pos, 47);
            check($sformatf("v%0d_done", v), done_cnt - d0, 1);
            check($sformatf("v%0d_busy", v), busy, 0);
            check($sformatf("v%0d_no_gap", v), drops, 0);
            check($sformatf("v%0d_addr", v), addr_seq_ok(addr_log, 2), 1);
        end
        brightness = 8'hFF;
        mem2[0] = vecs[0].pix0;
        mem2[1] = vecs[0].pix1;

        // Start held off by new_frame_rqst, then first-bit latency.
        new_frame_rqst = 1'b0;
        addr_log.delete();
        pulse_start();
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (fb_rd_en || busy) seen++;
        end
        check("hold_no_start", seen, 0);
        new_frame_rqst = 1'b1;
        @(negedge clk);
        check("lat_fetch", {fb_rd_en, busy, bit_valid, fb_addr}, {1'b1, 1'b1, 1'b0, 6'd0});
        @(negedge clk);
        check("lat_load", bit_valid, 0);
        @(negedge clk);
        check("lat_first_bit", {bit_valid, bit_to_transmit}, 2'b11);
        run_frame(48, 30, got, hits, pos, drops);
        check("lat_bits", got, vecs[0].exp_bits);

        // Two starts mid-frame merge into one pending frame.
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        pulse_start();
        run_frame(10, 30, got, hits, pos, drops);
        new_frame_rqst = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        run_frame(38, 30, got, hits, pos, drops);
        addr_log.delete();
        repeat (10) @(negedge clk);
        check("pend_wait", {busy, 8'(addr_log.size()), 8'(done_cnt - d0)}, {1'b0, 8'd0, 8'd1});
        new_frame_rqst = 1'b1;
        run_frame(48, 30, got, hits, pos, drops);
        check("pend_bits", got, vecs[0].exp_bits);
        repeat (20) @(negedge clk);
        check("pend_once", {busy, 8'(addr_log.size()), 8'(done_cnt - d0)}, {1'b0, 8'd2, 8'd2});

        // Reset during LED 1 bit 10.
        pulse_start();
        run_frame(34, 30, got, hits, pos, drops);
        check("pre_rst_active", {bit_valid, busy}, 2'b11);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("rst_mid_frame", {bit_valid, busy, fb_rd_en}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        addr_log.delete();
        pulse_start();
        run_frame(48, 30, got, hits, pos, drops);
        check("rst_restart_bits", got, vecs[0].exp_bits);
        check("rst_restart_addr", addr_seq_ok(addr_log, 2), 1);

        // 64 LEDs, request every 4 cycles.
        begin
            int errs = 0, b_drops = 0, b_hits = 0, b_pos = -1, t = 0;
            b_addr_log.delete();
            b_frame_start = 1'b1;
            @(negedge clk);
            b_frame_start = 1'b0;
            while (!b_bit_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("b_first_valid", b_bit_valid, 1);
            for (int k = 0; k < 1536; k++) begin
                logic [23:0] px;
                px = mem64[k / 24];
                if (!b_bit_valid) b_drops++;
                if (b_bit_to_transmit !== px[23 - (k % 24)]) errs++;
                if (b_all_bits_shifted) begin
                    b_hits++;
                    b_pos = k;
                end
                b_new_bit_rqst = 1'b1;
                @(negedge clk);
                b_new_bit_rqst = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (k < 1535 && !b_bit_valid) b_drops++;
                end
            end
            repeat (3) @(negedge clk);
            check("b_bit_errors", errs, 0);
            check("b_no_gap", b_drops, 0);
            check("b_abs_hits", b_hits, 1);
            check("b_abs_pos", b_pos, 1535);
            check("b_addr_order", addr_seq_ok(b_addr_log, 64), 1);
            check("b_done", {b_busy, 8'(b_done_cnt)}, {1'b0, 8'd1});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Sequences one full frame of WS2812 pixel data into the bit transmitter. Start is triggered by the game logic. The block reads 24-bit GRB words from the frame buffer through a synchronous read port, keeps one pixel prefetched, and presents bits MSB-first on each transmitter bit request. It flags the final bit of the frame and will not start a new frame until the transmitter reports that its latch/reset time has elapsed.

Parameters:
NUM_LEDS, 64, number of LEDs on the stripe (8x8 snake board); legal range 1..2**ADDR_W.
ADDR_W, 6, frame buffer address width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
frame_start  in  1  one-cycle pulse from game logic requesting a frame
new_frame_rqst  in  1  level from transmitter: high = idle, reset time done, frame may start
new_bit_rqst  in  1  one-cycle pulse from transmitter: current bit consumed, present next
bit_to_transmit  out  1  current bit to send
bit_valid  out  1  bit_to_transmit is valid
all_bits_shifted  out  1  high while bit_to_transmit is the last bit of the frame
fb_rd_en  out  1  frame buffer read enable
fb_addr  out  ADDR_W  frame buffer read address (LED index)
fb_rd_data  in  24  GRB pixel; valid exactly one cycle after fb_rd_en
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last bit is consumed
brightness  in  8  global scale; used only with the optional feature

Behaviour:
- Reset: all outputs 0. State IDLE. led_idx=0, bit_cnt=0. Pending-start flag and prefetch-valid flag cleared. Reset is honoured mid-frame; no completion pulse is generated.
- States: IDLE, FETCH, LOAD, SHIFT, DONE.
- IDLE: a start is pending when frame_start is seen now or was latched earlier. If a start is pending and new_frame_rqst=1, go to FETCH. Clear pending, set busy=1, set led_idx=0.
- FETCH: fb_rd_en=1 and fb_addr=led_idx for one cycle. Go to LOAD.
- LOAD: capture fb_rd_data (scaled if enabled) into the 24-bit shift register and set bit_cnt=0. Go to SHIFT. bit_valid rises on the cycle SHIFT is entered, so first-bit latency from start acceptance is 3 cycles.
- Prefetch: on the first SHIFT cycle of pixel i, if i<NUM_LEDS-1, issue a read of i+1. Capture the result one cycle later into nxt_pix and set nxt_valid.
- SHIFT: bit_to_transmit=shreg[23]. On new_bit_rqst with bit_cnt<23: shift left by 1, bit_cnt+1.
- On new_bit_rqst with bit_cnt=23:
  - If not the last LED: load shreg from nxt_pix, clear nxt_valid, increment led_idx, reset bit_cnt. bit_valid stays high with no gap.
  - If the last LED: go to DONE and drop bit_valid the next cycle.
- Transmitter contract: new_bit_rqst pulses are at least 4 cycles apart, so nxt_valid is always set before it is needed. If nxt_valid=0 at a pixel boundary, drop bit_valid until the prefetch lands (defensive).
- all_bits_shifted = bit_valid & (led_idx==NUM_LEDS-1) & (bit_cnt==23).
- DONE: pulse frame_done for 1 cycle, clear busy, go to IDLE.
- frame_start while busy: latched as pending (one deep; further pulses merge). The pending start is served in IDLE once new_frame_rqst=1.
- new_bit_rqst outside SHIFT: ignored.
- Bit order within each pixel: G[7:0], R[7:0], B[7:0], MSB first.
- NUM_LEDS=1: no prefetch issued; all_bits_shifted is high during bit 23 of pixel 0.

Optional Feature:
- Macro BRIGHTNESS_SCALE_EN.
- Defined: each 8-bit channel loaded into shreg/nxt_pix becomes (ch*(brightness+1))>>8, computed with a 16-bit intermediate and truncated to 8 bits. brightness=255 is identity; brightness=0 gives ch>>8 = 0.
- Undefined: pixels pass unmodified, and the brightness port exists but is ignored.

Test Plan:
1. NUM_LEDS=2; fb[0]=24'hA50F3C, fb[1]=24'h000001; pulse frame_start with new_frame_rqst=1; new_bit_rqst every 30 cycles. Expect 48 bits 1010_0101_0000_1111_0011_1100 then 23 zeros and a 1. all_bits_shifted high only during bit 47. frame_done pulses once; busy low afterwards.
2. Hold new_frame_rqst=0 and pulse frame_start. Expect no fb_rd_en and busy=0. Raise new_frame_rqst: fb_rd_en on the next cycle, and bit_valid 3 cycles after start acceptance.
3. Pulse frame_start twice mid-frame. Expect exactly one extra frame after frame_done, started once new_frame_rqst=1.
4. Assert rst during LED 1 bit 10. Expect immediate bit_valid=0, busy=0, fb_rd_en=0, no frame_done. A new frame_start after release restarts from fb_addr=0.
5. new_bit_rqst every 4 cycles for NUM_LEDS=64. Expect bit_valid never drops mid-frame, fb_addr reads 0..63 in order, 1536 bits total.
6. With BRIGHTNESS_SCALE_EN, brightness=8'h7F, pixel 24'hFF8002. Expect shifted word 24'h7F4001. With brightness=8'hFF, expect 24'hFF8002 unchanged.
